ecc_enc_dec_q: RTL and testbench

Parametrised, queued successor to the APB-programmed ECC encoder/decoder. Implements extended-Hamming SECDED for any power-of-two codeword width. Accepts encode, decode and full (encode, noise, decode) commands over an APB slave into a command FIFO. Returns results through a valid/ready output port, so the bench or a downstream consumer can apply back-pressure without losing commands.

---
 rtl/ecc_enc_dec_q.sv | 255 +++++++++++++++++++++++++
 tb/tb_ecc_enc_dec_q.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_enc_dec_q.sv
// ecc_enc_dec_q: APB-programmed extended-Hamming SECDED encoder/decoder with a
// command FIFO and a valid/ready result port.
module ecc_enc_dec_q #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned AMBA_ADDR_WIDTH = 20,
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned CMD_DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    input  logic                       PENABLE,
    input  logic                       PSEL,
    input  logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 num_of_errors
);

    localparam int unsigned N    = DATA_WIDTH;
    localparam int unsigned LOGN = $clog2(N);
    localparam int unsigned K    = N - LOGN - 1;
    localparam int unsigned PW   = $clog2(CMD_DEPTH);
    localparam int unsigned CW   = PW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_HOLD} state_t;

    // XOR of the indices of all set bits in positions 1..N-1
    function automatic logic [LOGN-1:0] ecc_syndrome(input logic [N-1:0] cw);
        logic [LOGN-1:0] s;
        s = '0;
        for (int unsigned i = 1; i < N; i++) begin
            if (cw[i]) s = s ^ LOGN'(i);
        end
        return s;
    endfunction

    // Scatter data into non-power-of-two positions, then fill parity bits
    function automatic logic [N-1:0] ecc_encode(input logic [K-1:0] d);
        logic [N-1:0]    cw;
        logic [K-1:0]    dd;
        logic [LOGN-1:0] s;
        cw = '0;
        dd = d;
        for (int unsigned i = 1; i < N; i++) begin
            if ((i & (i - 1)) != 0) begin
                cw[i] = dd[0];
                dd    = dd >> 1;
            end
        end
        // syndrome of the data-only word is exactly the parity each group needs
        s = ecc_syndrome(cw);
        for (int unsigned k = 0; k < LOGN; k++) begin
            cw[1 << k] = s[k];
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    // Returns {num_of_errors, zero-extended data}
    function automatic logic [N+1:0] ecc_decode(input logic [N-1:0] cw);
        logic [LOGN-1:0] s;
        logic [N-1:0]    fixed;
        logic [K-1:0]    dd;
        logic [1:0]      err;
        s     = ecc_syndrome(cw);
        fixed = cw;
        err   = 2'b00;
        if (^cw) begin
            fixed = cw ^ (N'(1) << s);
            err   = 2'b01;
        end else if (s != '0) begin
            err = 2'b10;
        end
        dd = '0;
        for (int i = N - 1; i >= 1; i--) begin
            if ((i & (i - 1)) != 0) dd = {dd[K-2:0], fixed[i]};
        end
        return {err, N'(dd)};
    endfunction

    logic [1:0]    ctrl_reg;
    logic [N-1:0]  data_in_reg;
    logic [N-1:0]  noise_reg;
    logic          overflow;

    logic [1:0]    fifo_op    [CMD_DEPTH];
    logic [N-1:0]  fifo_data  [CMD_DEPTH];
    logic [N-1:0]  fifo_noise [CMD_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    state_t        state;
    logic [1:0]    cur_op;
    logic [N-1:0]  cur_data;
    logic [N-1:0]  cur_noise;

    logic [1:0]    reg_sel;
    logic          apb_wr;
    logic          apb_setup_rd;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_req;
    logic          push;
    logic          drop;
    logic          pop;

    logic [N-1:0]  enc_cw;
    logic [N-1:0]  dec_in;
    logic [N+1:0]  dec_res;
    logic [N-1:0]  res_data;
    logic [1:0]    res_err;
    logic [AMBA_WORD-1:0] rd_mux;

    logic          unused_apb;
    assign unused_apb = ^{PADDR, PWDATA};

    assign reg_sel      = PADDR[3:2];
    assign apb_wr       = PSEL & PENABLE & PWRITE;
    assign apb_setup_rd = PSEL & ~PENABLE & ~PWRITE;
    assign fifo_full    = (count == CW'(CMD_DEPTH));
    assign fifo_empty   = (count == '0);
    assign push_req     = apb_wr && (reg_sel == 2'd0) && (PWDATA[1:0] != 2'd3);
    assign push         = push_req && !fifo_full;
    assign drop         = push_req && fifo_full;
    assign pop          = (state == ST_IDLE) && !fifo_empty;

    // Programming registers and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_reg    <= '0;
            data_in_reg <= '0;
            noise_reg   <= '0;
            overflow    <= 1'b0;
        end else begin
            if (apb_wr) begin
                case (reg_sel)
                    2'd0: ctrl_reg    <= PWDATA[1:0];
                    2'd1: data_in_reg <= PWDATA[N-1:0];
                    2'd2: noise_reg   <= PWDATA[N-1:0];
                    default: if (PWDATA[2]) overflow <= 1'b0;
                endcase
            end
            if (drop) overflow <= 1'b1;
        end
    end

    // Command FIFO: snapshot of op, DATA_IN and NOISE at CTRL write time
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < CMD_DEPTH; i++) begin
                fifo_op[i]    <= '0;
                fifo_data[i]  <= '0;
                fifo_noise[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_op[wr_ptr]    <= PWDATA[1:0];
                fifo_data[wr_ptr]  <= data_in_reg;
                fifo_noise[wr_ptr] <= noise_reg;
                wr_ptr             <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Result of the command held by the engine
    always_comb begin
        enc_cw  = ecc_encode(cur_data[K-1:0]);
        dec_in  = (cur_op == 2'd2) ? (enc_cw ^ cur_noise) : cur_data;
        dec_res = ecc_decode(dec_in);
        if (cur_op == 2'd0) begin
            res_data = enc_cw;
            res_err  = 2'b00;
        end else begin
            res_data = dec_res[N-1:0];
            res_err  = dec_res[N+1:N];
        end
    end

    // Engine FSM: pop, compute, hold until the consumer accepts
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            out_valid     <= 1'b0;
            data_out      <= '0;
            num_of_errors <= 2'b00;
            cur_op        <= '0;
            cur_data      <= '0;
            cur_noise     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur_op    <= fifo_op[rd_ptr];
                        cur_data  <= fifo_data[rd_ptr];
                        cur_noise <= fifo_noise[rd_ptr];
                        state     <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    data_out      <= res_data;
                    num_of_errors <= res_err;
                    out_valid     <= 1'b1;
                    state         <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read mux for the register selected by PADDR
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            2'd0: rd_mux[1:0]   = ctrl_reg;
            2'd1: rd_mux[N-1:0] = data_in_reg;
            2'd2: rd_mux[N-1:0] = noise_reg;
            default: begin
                rd_mux[0]    = fifo_empty;
                rd_mux[1]    = fifo_full;
                rd_mux[2]    = overflow;
                rd_mux[15:8] = 8'(count);
            end
        endcase
    end

    // PRDATA captured on the setup phase so it is valid through the access edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            PRDATA <= '0;
        end else if (apb_setup_rd) begin
            PRDATA <= rd_mux;
        end
    end

endmodule

// File: tb/tb_ecc_enc_dec_q.sv
// tb_ecc_enc_dec_q: directed and randomized checks of ecc_enc_dec_q at N=8.
module tb_ecc_enc_dec_q;

    localparam int N     = 8;
    localparam int K     = 4;
    localparam int AW    = 20;
    localparam int WORD  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   PADDR;
    logic [WORD-1:0] PWDATA;
    logic            PENABLE;
    logic            PSEL;
    logic            PWRITE;
    logic [WORD-1:0] PRDATA;
    logic [N-1:0]    data_out;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      num_of_errors;

    always #5 clk = ~clk;

    ecc_enc_dec_q #(
        .DATA_WIDTH(N), .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(WORD), .CMD_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .PADDR(PADDR), .PWDATA(PWDATA), .PENABLE(PENABLE),
        .PSEL(PSEL), .PWRITE(PWRITE), .PRDATA(PRDATA), .data_out(data_out),
        .out_valid(out_valid), .out_ready(out_ready), .num_of_errors(num_of_errors)
    );

    typedef struct {
        logic [N-1:0] data;
        logic [1:0]   err;
    } res_t;

    res_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_pow2(input int x);
        return $countones(x) == 1;
    endfunction

    // Reference encoder straight from the SECDED definition
    function automatic logic [N-1:0] m_encode(input logic [K-1:0] d);
        logic [N-1:0] cw;
        int j;
        bit par;
        cw = '0;
        j  = 0;
        for (int pos = 1; pos < N; pos++) begin
            if (!is_pow2(pos)) begin
                cw[pos] = d[j];
                j++;
            end
        end
        for (int k = 0; (1 << k) < N; k++) begin
            par = 1'b0;
            for (int pos = 1; pos < N; pos++) begin
                if (((pos >> k) & 1) == 1 && !is_pow2(pos)) par = par ^ cw[pos];
            end
            cw[1 << k] = par;
        end
        cw[0] = ($countones(cw) % 2) == 1;
        return cw;
    endfunction

    function automatic res_t m_decode(input logic [N-1:0] cw);
        res_t r;
        int s;
        int j;
        logic [N-1:0] fix;
        s = 0;
        for (int pos = 1; pos < N; pos++) if (cw[pos]) s = s ^ pos;
        fix = cw;
        if (($countones(cw) % 2) == 1) begin
            fix[s] = ~fix[s];
            r.err  = 2'b01;
        end else if (s != 0) begin
            r.err = 2'b10;
        end else begin
            r.err = 2'b00;
        end
        r.data = '0;
        j = 0;
        for (int pos = 1; pos < N; pos++) begin
            if (!is_pow2(pos)) begin
                r.data[j] = fix[pos];
                j++;
            end
        end
        return r;
    endfunction

    function automatic res_t m_cmd(input int op, input logic [31:0] din, input logic [31:0] noise);
        res_t r;
        if (op == 0) begin
            r.data = m_encode(din[K-1:0]);
            r.err  = 2'b00;
        end else if (op == 1) begin
            r = m_decode(din[N-1:0]);
        end else begin
            r = m_decode(m_encode(din[K-1:0]) ^ noise[N-1:0]);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input int r, input logic [31:0] d);
        PADDR   = AW'(r * 4);
        PWDATA  = d;
        PWRITE  = 1'b1;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apb_read(input int r, output logic [31:0] d);
        PADDR   = AW'(r * 4);
        PWRITE  = 1'b0;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        tick();
        PENABLE = 1'b1;
        tick();
        d       = PRDATA;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic send_cmd(input int op, input logic [31:0] din, input logic [31:0] noise);
        apb_write(1, din);
        apb_write(2, noise);
        apb_write(0, 32'(op));
    endtask

    // Waits (bounded) for a result, compares it with the queue head, then accepts it
    task automatic get_result(input string tag);
        int   n;
        res_t e;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        e = exp_q.pop_front();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (out_valid) begin
            check({tag, "_data"}, 32'(data_out), 32'(e.data));
            check({tag, "_err"}, 32'(num_of_errors), 32'(e.err));
            out_ready = 1'b1;
            tick();
            check({tag, "_accept"}, 32'(out_valid), 32'd0);
        end
    endtask

    function automatic logic [31:0] rand_noise();
        logic [31:0] nz;
        nz = $urandom;
        nz[N-1:0] = '0;
        repeat ($urandom_range(0, 2)) nz[$urandom_range(0, N - 1)] ^= 1'b1;
        return nz;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] din;
        logic [31:0] nz;
        logic [N-1:0] cw;
        int op;
        int n;
        bit saw;

        rst = 1'b0; PADDR = '0; PWDATA = '0; PENABLE = 1'b0; PSEL = 1'b0;
        PWRITE = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_err", 32'(num_of_errors), 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        rst = 1'b1;
        tick();
        apb_read(3, rd);
        check("rst_status", rd, 32'h1);

        // Encode 0x0B with latency check
        apb_write(1, 32'h0B);
        apb_write(2, 32'h0);
        apb_write(0, 32'h0);
        check("lat_t0", 32'(out_valid), 32'd0);
        tick();
        check("lat_t1", 32'(out_valid), 32'd0);
        tick();
        check("lat_t2", 32'(out_valid), 32'd1);
        check("enc_data", 32'(data_out), 32'hAA);
        check("enc_err", 32'(num_of_errors), 32'd0);
        tick();
        check("enc_accept", 32'(out_valid), 32'd0);

        // Full with single-bit noise on a parity position
        apb_write(2, 32'h04);
        apb_write(0, 32'h2);
        exp_q.push_back('{data: 8'h0B, err: 2'b01});
        get_result("full_single");

        // Full with double-bit noise
        apb_write(2, 32'h06);
        apb_write(0, 32'h2);
        exp_q.push_back('{data: 8'h0B, err: 2'b10});
        get_result("full_double");

        // Decode of a word with only the overall parity bit set
        apb_write(1, 32'h1);
        apb_write(0, 32'h1);
        exp_q.push_back('{data: 8'h00, err: 2'b01});
        get_result("dec_p0");

        apb_read(0, rd);
        check("rd_ctrl", rd, 32'h1);
        apb_read(1, rd);
        check("rd_data_in", rd, 32'h1);
        apb_read(2, rd);
        check("rd_noise", rd, 32'h6);

        // Reserved op updates CTRL but enqueues nothing
        apb_write(0, 32'h3);
        saw = 1'b0;
        repeat (6) begin
            tick();
            if (out_valid) saw = 1'b1;
        end
        check("op3_noresult", 32'(saw), 32'd0);
        apb_read(0, rd);
        check("rd_ctrl_op3", rd, 32'h3);
        tick();
        check("prdata_hold", PRDATA, 32'h3);
        apb_read(3, rd);
        check("op3_status", rd, 32'h1);

        // Back-pressure: one in the engine, four queued, sixth dropped
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            din = $urandom;
            send_cmd(0, din, 32'h0);
            if (i < 5) exp_q.push_back(m_cmd(0, din, 32'h0));
        end
        apb_read(3, rd);
        check("ovf_status", rd, 32'h406);
        check("ovf_held", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) get_result("ovf_drain");
        apb_read(3, rd);
        check("ovf_empty", rd, 32'h5);
        apb_write(3, 32'h4);
        apb_read(3, rd);
        check("ovf_clear", rd, 32'h1);

        // Randomized bursts against the reference model
        for (int g = 0; g < 12; g++) begin
            n = $urandom_range(1, 4);
            out_ready = 1'b0;
            for (int j = 0; j < n; j++) begin
                op  = $urandom_range(0, 2);
                din = $urandom;
                nz  = rand_noise();
                if (op == 1) begin
                    cw = m_encode(din[K-1:0]) ^ nz[N-1:0];
                    din[N-1:0] = cw;
                end
                send_cmd(op, din, nz);
                exp_q.push_back(m_cmd(op, din, nz));
            end
            for (int j = 0; j < n; j++) get_result("rnd");
        end

        // Reset with a result held and two commands queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_cmd(0, $urandom, 32'h0);
        check("mid_held", 32'(out_valid), 32'd1);
        apb_read(3, rd);
        check("mid_status", rd, 32'h200);
        rst = 1'b0;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(data_out), 32'd0);
        check("mid_rst_prdata", PRDATA, 32'd0);
        rst = 1'b1;
        apb_read(3, rd);
        check("mid_rst_status", rd, 32'h1);
        out_ready = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            tick();
            if (out_valid) saw = 1'b1;
        end
        check("mid_flushed", 32'(saw), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
